// File: rtl/uart_rx_fifo.sv
// Receive-side byte FIFO for the UART: captures one byte per rising edge of the
// receiver's data-ready level and hands bytes to the host through a FWFT valid/ready port.
module uart_rx_fifo #(
    parameter int DATA_W     = 8,
    parameter int DEPTH_LOG2 = 4,
    parameter int THRESH     = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_W-1:0]     din,
    input  logic                  din_rdy,
    input  logic                  clr,
    input  logic                  ovf_clr,
    output logic [DATA_W-1:0]     m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  thresh_hit,
    output logic                  overflow
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C  = (DEPTH_LOG2 + 1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   THRESH_C = (DEPTH_LOG2 + 1)'(THRESH);
    localparam logic [DEPTH_LOG2-1:0] PTR_INC  = (DEPTH_LOG2)'(1'b1);
    localparam logic [DEPTH_LOG2:0]   CNT_INC  = (DEPTH_LOG2 + 1)'(1'b1);

    logic [DATA_W-1:0]     mem_r [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_r;
    logic [DEPTH_LOG2-1:0] rd_ptr_r;
    logic [DEPTH_LOG2:0]   count_r;
    logic                  din_rdy_q_r;
    logic                  overflow_r;

    logic                  wr_ev_s;
    logic                  pop_s;
    logic                  wr_en_s;
    logic                  ovf_ev_s;
    logic                  full_s;
    logic                  empty_s;

    assign full_s  = (count_r == DEPTH_C);
    assign empty_s = (count_r == {(DEPTH_LOG2 + 1){1'b0}});
    assign wr_ev_s = din_rdy && !din_rdy_q_r;
    assign pop_s   = !empty_s && m_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign wr_en_s  = wr_ev_s && (!full_s || pop_s);
    assign ovf_ev_s = wr_ev_s && full_s && !pop_s;

    assign m_valid    = !empty_s;
    assign full       = full_s;
    assign empty      = empty_s;
    assign thresh_hit = (count_r >= THRESH_C);
    assign count      = count_r;
    assign overflow   = overflow_r;

    // Head-of-FIFO read; forced to zero while empty so the idle value is defined.
    always_comb begin
        m_data = {DATA_W{1'b0}};
        if (empty_s) begin
            m_data = {DATA_W{1'b0}};
        end else begin
            m_data = mem_r[rd_ptr_r];
        end
    end

    // Storage array, deliberately without reset.
    always_ff @(posedge clk) begin
        if (wr_en_s && !clr) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointers, fill count, edge-detect history and sticky overflow.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_r    <= {DEPTH_LOG2{1'b0}};
            rd_ptr_r    <= {DEPTH_LOG2{1'b0}};
            count_r     <= {(DEPTH_LOG2 + 1){1'b0}};
            din_rdy_q_r <= 1'b0;
            overflow_r  <= 1'b0;
        end else begin
            // History always follows the level so a held ready never recaptures after clr.
            din_rdy_q_r <= din_rdy;
            if (clr) begin
                wr_ptr_r   <= {DEPTH_LOG2{1'b0}};
                rd_ptr_r   <= {DEPTH_LOG2{1'b0}};
                count_r    <= {(DEPTH_LOG2 + 1){1'b0}};
                overflow_r <= 1'b0;
            end else begin
                if (wr_en_s) begin
                    wr_ptr_r <= wr_ptr_r + PTR_INC;
                end else begin
                    wr_ptr_r <= wr_ptr_r;
                end
                if (pop_s) begin
                    rd_ptr_r <= rd_ptr_r + PTR_INC;
                end else begin
                    rd_ptr_r <= rd_ptr_r;
                end
                case ({wr_en_s, pop_s})
                    2'b10:   count_r <= count_r + CNT_INC;
                    2'b01:   count_r <= count_r - CNT_INC;
                    default: count_r <= count_r;
                endcase
                if (ovf_ev_s) begin
                    overflow_r <= 1'b1;
                end else if (ovf_clr) begin
                    overflow_r <= 1'b0;
                end else begin
                    overflow_r <= overflow_r;
                end
            end
        end
    end

endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
- Receive buffer that sits directly downstream of the UART byte receiver.
- Captures each received byte on the rising edge of the receiver's level-type data-ready flag and stores it in a circular FIFO.
- Presents bytes to the host side through a first-word-fall-through valid/ready interface.
- Reports fill level, full/empty, a programmable threshold flag and a sticky overflow flag for the controller status register.

Parameters:
DATA_W, 8, byte width; must match receiver output width.
DEPTH_LOG2, 4, log2 of FIFO depth (default depth 16 entries).
THRESH, 8, fill level at or above which thresh_hit asserts; legal range 1..2**DEPTH_LOG2.

Ports:
clk  input  1  system clock; all logic on posedge.
rst  input  1  reset, asynchronous, active-high.
din  input  DATA_W  received byte from receiver; valid whenever din_rdy is high.
din_rdy  input  1  receiver data-ready level; may stay high for many clk cycles per byte.
clr  input  1  synchronous flush, one-cycle pulse.
ovf_clr  input  1  synchronous clear of overflow only.
m_data  output  DATA_W  head-of-FIFO byte; valid while m_valid is high.
m_valid  output  1  FIFO not empty.
m_ready  input  1  consumer accepts m_data; pop occurs when m_valid && m_ready.
count  output  DEPTH_LOG2+1  current number of stored entries, 0..2**DEPTH_LOG2.
full  output  1  count == 2**DEPTH_LOG2.
empty  output  1  count == 0.
thresh_hit  output  1  count >= THRESH.
overflow  output  1  sticky: a byte was dropped because the FIFO was full.

Behaviour:
- Reset values:
  - Read/write pointers, count and the din_rdy history register are 0.
  - overflow is 0; empty is 1; full, m_valid and thresh_hit are 0.
  - m_data is 0. Memory contents are not reset.
- Write event (wr_ev) = din_rdy && !din_rdy_q, where din_rdy_q is din_rdy registered.
  - Exactly one capture per receiver byte, regardless of how long din_rdy stays high.
  - din is sampled in the wr_ev cycle.
- Pop event = m_valid && m_ready.
  - In the pop cycle the read pointer advances and m_data changes to the next entry (or holds if the FIFO becomes empty).
- FWFT latency:
  - A byte written at edge N is on m_data with m_valid=1 after edge N, i.e. in the cycle following the wr_ev cycle.
  - m_data is a combinational read of mem[rd_ptr] and must be stable while m_valid=1 and no pop occurs.
- Pointers are DEPTH_LOG2 bits and wrap modulo depth. count is updated +1 on write only, -1 on pop only, unchanged on both or neither.
- Boundary conditions:
  - Full + wr_ev + no pop: byte dropped, memory and pointers unchanged, overflow set to 1 at the next edge.
  - Full + wr_ev + pop in the same cycle: both performed, no overflow, count stays at full.
  - Empty + wr_ev + m_ready: no pop (m_valid=0); count becomes 1.
  - Pointer wrap from depth-1 to 0 is seamless; ordering is strictly preserved.
- Priority:
  - clr takes priority over everything. Pointers and count go to 0 and overflow goes to 0. Any coincident wr_ev or pop is discarded. din_rdy_q still updates, so a level held across clr does not re-capture.
  - When an overflow event and ovf_clr occur in the same cycle, overflow ends at 1 (set wins).
  - ovf_clr alone clears overflow and has no effect on data.
- Status outputs:
  - full, empty and thresh_hit are combinational decodes of the count register.
  - m_valid = !empty.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). If din_rdy is high at reset release, it is captured as a wr_ev on the first clock edge.

Test Plan:
- Single byte, long ready: din=0xA5, din_rdy high for 40 cycles, m_ready=0 -> count=1 (not 40), m_valid=1 and m_data=0xA5 from the cycle after the edge. Then pulse m_ready -> empty=1, count=0.
- Order and wrap: write 0x00..0x13 (20 bytes) while popping every other cycle after the 10th write -> output sequence is exactly 0x00..0x13, with no overflow.
- Overflow: write 17 bytes 0x10..0x20 with m_ready=0 -> full=1, count=16, overflow=1, head=0x10, last stored=0x1F, 0x20 dropped. Then ovf_clr -> overflow=0 with data intact.
- Full with simultaneous write and pop: FIFO full at 16, wr_ev and m_ready in the same cycle -> count stays 16, overflow stays 0, new byte appears at the tail.
- Threshold and clr: with THRESH=8, the 8th write sets thresh_hit=1 and the next pop clears it. Then clr issued in the same cycle as a wr_ev -> count=0, empty=1, overflow=0, byte discarded.
- Async reset mid-stream with 5 entries stored -> count=0, m_valid=0, overflow=0 immediately on rst, without waiting for a clock edge.
